// File: rtl/ukf_lower_read_scheduler_if.sv
// Bus between the lower-triangle read scheduler, the four lower-lane FIFOs and the lower PE.
// Handshake: a read fires only in a cycle where the owning lane is non-empty and pe_ready=1; pe_valid follows exactly one cycle later, is never held and needs no ready of its own.
interface ukf_lower_read_scheduler_if #(
  parameter int SIZE_W  = 6,
  parameter int STALL_W = 16
) ();
  logic               start;
  logic [SIZE_W-1:0]  matrix_size;
  logic [3:0]         empty_l;
  logic               pe_ready;
  logic [3:0]         fifo_rde_l;
  logic               pe_valid;
  logic [SIZE_W-1:0]  pe_row;
  logic [SIZE_W-1:0]  pe_col;
  logic               pe_last;
  logic               busy;
  logic               stall;
  logic               done;
  logic [STALL_W-1:0] stall_cycles;

  // master is the scheduler; slave is the FIFO/PE side driving requests and flags.
  modport master (
    input  start, matrix_size, empty_l, pe_ready,
    output fifo_rde_l, pe_valid, pe_row, pe_col, pe_last, busy, stall, done, stall_cycles
  );
  modport slave (
    output start, matrix_size, empty_l, pe_ready,
    input  fifo_rde_l, pe_valid, pe_row, pe_col, pe_last, busy, stall, done, stall_cycles
  );
endinterface

// File: rtl/ukf_lower_read_scheduler.sv
// Walks the strictly-lower triangle column-major, reading row r from lane r mod 4 into the lower PE.
// Optional stall counter enabled by defining UKF_SCHED_STALL_CNT_EN.
module ukf_lower_read_scheduler #(
  parameter int SIZE_W  = 6,
  parameter int STALL_W = 16
) (
  input  logic                          slow_clock,
  input  logic                          rst,
  ukf_lower_read_scheduler_if.master    bus,
  output logic [1:0]                    state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [SIZE_W-1:0]   n_q, row_q, col_q;
  logic [SIZE_W-1:0]   pe_row_q, pe_col_q;
  logic                pe_valid_q, pe_last_q;
  logic [1:0]          lane;
  logic                issue, row_is_last, last_elem, start_acc;
  logic [3:0]          rde_w;
  logic                stall_w;
  logic [STALL_W-1:0]  stall_cycles_w;

  assign lane        = row_q[1:0];
  assign issue       = (state_q == ISSUE) && !bus.empty_l[lane] && bus.pe_ready;
  assign row_is_last = (row_q == n_q - SIZE_W'(1));
  assign last_elem   = row_is_last && (col_q == n_q - SIZE_W'(2));
  assign start_acc   = (state_q == IDLE) && bus.start;

  always_comb begin
    state_d = state_q;
    rde_w   = 4'b0000;
    stall_w = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = (bus.matrix_size >= SIZE_W'(2)) ? ISSUE : DONE;
      end
      ISSUE: begin
        if (issue) begin
          rde_w = 4'b0001 << lane;
          if (last_elem) state_d = DRAIN;
        end else begin
          stall_w = 1'b1;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (!rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      pe_row_q   <= '0;
      pe_col_q   <= '0;
      pe_valid_q <= 1'b0;
      pe_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pe_valid_q <= issue;
      pe_last_q  <= issue && last_elem;
      if (issue) begin
        pe_row_q <= row_q;
        pe_col_q <= col_q;
      end
      if (start_acc) begin
        n_q   <= bus.matrix_size;
        col_q <= '0;
        row_q <= SIZE_W'(1);
      end else if (issue && !last_elem) begin
        // Bottom of a column: the next column starts just below its diagonal.
        if (row_is_last) begin
          col_q <= col_q + SIZE_W'(1);
          row_q <= col_q + SIZE_W'(2);
        end else begin
          row_q <= row_q + SIZE_W'(1);
        end
      end
    end
  end

`ifdef UKF_SCHED_STALL_CNT_EN
  logic [STALL_W-1:0] stall_cnt_q;

  always_ff @(posedge slow_clock) begin
    if (!rst)                                 stall_cnt_q <= '0;
    else if (start_acc)                       stall_cnt_q <= '0;
    else if (stall_w && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + STALL_W'(1);
  end

  assign stall_cycles_w = stall_cnt_q;
`else
  assign stall_cycles_w = {STALL_W{1'b0}};
`endif

  assign bus.fifo_rde_l   = rde_w;
  assign bus.stall        = stall_w;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.pe_valid     = pe_valid_q;
  assign bus.pe_last      = pe_last_q;
  assign bus.pe_row       = pe_row_q;
  assign bus.pe_col       = pe_col_q;
  assign bus.stall_cycles = stall_cycles_w;
  assign state_dbg        = state_q;
endmodule

// File: tb/tb_ukf_lower_read_scheduler.sv
// Bench for ukf_lower_read_scheduler: directed scenarios plus randomized walks against a schedule model.
`timescale 1ns/1ps
module tb_ukf_lower_read_scheduler;
  localparam int SIZE_W  = 6;
  localparam int STALL_W = 16;
  localparam int DEPTH   = 4096;

  logic slow_clock = 1'b0;
  logic rst = 1'b0;
  logic [1:0] state_dbg;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] emp_arr [DEPTH];
  logic       rdy_arr [DEPTH];

  typedef struct { int c; logic [3:0] v; } rd_t;
  typedef struct { int c; logic [SIZE_W-1:0] r; logic [SIZE_W-1:0] k; logic l; } pe_t;
  rd_t rd_log[$];
  pe_t pe_log[$];
  int  done_log[$];
  int  stall_log[$];
  logic [2*SIZE_W-1:0] exp_q[$];

  ukf_lower_read_scheduler_if #(.SIZE_W(SIZE_W), .STALL_W(STALL_W)) bus ();

  ukf_lower_read_scheduler #(.SIZE_W(SIZE_W), .STALL_W(STALL_W)) dut (
    .slow_clock (slow_clock),
    .rst        (rst),
    .bus        (bus),
    .state_dbg  (state_dbg)
  );

  always #5 slow_clock = ~slow_clock;

  // Observation log, sampled mid-cycle and tagged with the cycle number.
  always @(negedge slow_clock) begin
    if (bus.fifo_rde_l != 4'b0000) rd_log.push_back('{cyc, bus.fifo_rde_l});
    if (bus.pe_valid) pe_log.push_back('{cyc, bus.pe_row, bus.pe_col, bus.pe_last});
    if (bus.done) done_log.push_back(cyc);
    if (bus.stall) stall_log.push_back(cyc);
  end

  task automatic tick();
    @(posedge slow_clock);
    cyc++;
    #1;
    bus.empty_l  = emp_arr[cyc % DEPTH];
    bus.pe_ready = rdy_arr[cyc % DEPTH];
  endtask

  // mode 0: all lanes full, PE ready; 1: random; 2: pe_ready high on even cycles only.
  task automatic set_stim(input int from, input int cnt, input int mode);
    for (int i = 0; i < cnt; i++) begin
      int idx = (from + i) % DEPTH;
      case (mode)
        1:       begin emp_arr[idx] = 4'($urandom_range(0, 15)); rdy_arr[idx] = ($urandom_range(0, 3) != 0); end
        2:       begin emp_arr[idx] = 4'b0000; rdy_arr[idx] = ((from + i) % 2 == 0); end
        default: begin emp_arr[idx] = 4'b0000; rdy_arr[idx] = 1'b1; end
      endcase
    end
  endtask

  function automatic void build_order(input int n);
    exp_q.delete();
    for (int c = 0; c < n - 1; c++)
      for (int r = c + 1; r < n; r++)
        exp_q.push_back({SIZE_W'(r), SIZE_W'(c)});
  endfunction

  task automatic launch(input int n, output int s);
    tick();
    s = cyc;
    bus.start = 1'b1;
    bus.matrix_size = SIZE_W'(n);
    tick();
    bus.start = 1'b0;
    bus.matrix_size = SIZE_W'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int db = done_log.size();
    int k = 0;
    while (done_log.size() == db && k < budget) begin
      tick();
      k++;
    end
    ok = (done_log.size() != db);
  endtask

  task automatic test_reset();
    tick(); tick();
    @(negedge slow_clock);
    checks++; if (bus.fifo_rde_l !== 4'b0) begin errors++; $display("FAIL reset_rde got %b want 0000", bus.fifo_rde_l); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    checks++; if (bus.pe_valid !== 1'b0) begin errors++; $display("FAIL reset_pe_valid got %b want 0", bus.pe_valid); end
    checks++; if (bus.pe_last !== 1'b0) begin errors++; $display("FAIL reset_pe_last got %b want 0", bus.pe_last); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.pe_row !== '0 || bus.pe_col !== '0) begin errors++; $display("FAIL reset_idx got %0d,%0d want 0,0", bus.pe_row, bus.pe_col); end
    checks++; if (bus.stall_cycles !== '0) begin errors++; $display("FAIL reset_stall_cycles got %0d want 0", bus.stall_cycles); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_basic_n4();
    logic [3:0] exp_v [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b1000};
    int exp_r [6] = '{1, 2, 3, 2, 3, 3};
    int exp_c [6] = '{0, 0, 0, 1, 1, 2};
    int s, rb, pb;
    bit ok;
    set_stim(cyc + 1, 40, 0);
    rb = rd_log.size(); pb = pe_log.size();
    launch(4, s);
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no done want done"); end
    checks++; if (rd_log.size() - rb != 6) begin errors++; $display("FAIL basic_read_count got %0d want 6", rd_log.size() - rb); end
    for (int i = 0; i < 6 && rb + i < rd_log.size(); i++) begin
      checks++;
      if (rd_log[rb+i].c != s + 1 + i || rd_log[rb+i].v !== exp_v[i]) begin
        errors++; $display("FAIL basic_read%0d got cyc %0d %b want cyc %0d %b", i, rd_log[rb+i].c - s, rd_log[rb+i].v, 1 + i, exp_v[i]);
      end
    end
    checks++; if (pe_log.size() - pb != 6) begin errors++; $display("FAIL basic_pe_count got %0d want 6", pe_log.size() - pb); end
    for (int i = 0; i < 6 && pb + i < pe_log.size(); i++) begin
      pe_t p = pe_log[pb+i];
      checks++;
      if (p.c != s + 2 + i || int'(p.r) != exp_r[i] || int'(p.k) != exp_c[i] || p.l !== (i == 5)) begin
        errors++; $display("FAIL basic_pe%0d got cyc %0d (%0d,%0d) last %b want cyc %0d (%0d,%0d) last %b",
                           i, p.c - s, p.r, p.k, p.l, 2 + i, exp_r[i], exp_c[i], (i == 5));
      end
    end
    checks++; if (ok && done_log[done_log.size()-1] != s + 8) begin errors++; $display("FAIL basic_done_cycle got %0d want 8", done_log[done_log.size()-1] - s); end
    @(negedge slow_clock);
    checks++; if (bus.busy !== 1'b0 || cyc != s + 9) begin errors++; $display("FAIL basic_busy_end got busy %b at cyc %0d want 0 at 9", bus.busy, cyc - s); end
  endtask

  task automatic test_n1();
    int s, rb;
    set_stim(cyc + 1, 20, 0);
    rb = rd_log.size();
    launch(1, s);
    @(negedge slow_clock);
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b1) begin errors++; $display("FAIL n1_done got busy %b done %b want 1 1", bus.busy, bus.done); end
    tick();
    @(negedge slow_clock);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL n1_idle got busy %b done %b want 0 0", bus.busy, bus.done); end
    repeat (4) tick();
    checks++; if (rd_log.size() != rb) begin errors++; $display("FAIL n1_reads got %0d want 0", rd_log.size() - rb); end
  endtask

  task automatic test_lane_stall();
    int offs [6] = '{1, 5, 6, 7, 8, 9};
    logic [3:0] exp_v [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b1000};
    int s, rb, sb;
    bit ok;
    set_stim(cyc + 1, 60, 0);
    for (int i = 2; i <= 4; i++) emp_arr[(cyc + 1 + i) % DEPTH] = 4'b0100;
    rb = rd_log.size(); sb = stall_log.size();
    launch(4, s);
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lane_stall_timeout got no done want done"); end
    checks++; if (rd_log.size() - rb != 6) begin errors++; $display("FAIL lane_stall_reads got %0d want 6", rd_log.size() - rb); end
    for (int i = 0; i < 6 && rb + i < rd_log.size(); i++) begin
      checks++;
      if (rd_log[rb+i].c != s + offs[i] || rd_log[rb+i].v !== exp_v[i]) begin
        errors++; $display("FAIL lane_stall_read%0d got cyc %0d %b want cyc %0d %b", i, rd_log[rb+i].c - s, rd_log[rb+i].v, offs[i], exp_v[i]);
      end
    end
    checks++; if (stall_log.size() - sb != 3) begin errors++; $display("FAIL lane_stall_count got %0d want 3", stall_log.size() - sb); end
    for (int i = 0; i < 3 && sb + i < stall_log.size(); i++) begin
      checks++; if (stall_log[sb+i] != s + 2 + i) begin errors++; $display("FAIL lane_stall_cycle%0d got %0d want %0d", i, stall_log[sb+i] - s, 2 + i); end
    end
    checks++; if (ok && done_log[done_log.size()-1] != s + 11) begin errors++; $display("FAIL lane_stall_done got %0d want 11", done_log[done_log.size()-1] - s); end
`ifdef UKF_SCHED_STALL_CNT_EN
    checks++; if (bus.stall_cycles !== STALL_W'(3)) begin errors++; $display("FAIL lane_stall_cycles got %0d want 3", bus.stall_cycles); end
`else
    checks++; if (bus.stall_cycles !== '0) begin errors++; $display("FAIL lane_stall_cycles got %0d want 0", bus.stall_cycles); end
`endif
  endtask

  task automatic test_ready_toggle();
    int s, rb, pb;
    bit ok;
    set_stim(cyc + 1, 120, 2);
    build_order(6);
    rb = rd_log.size(); pb = pe_log.size();
    launch(6, s);
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL toggle_timeout got no done want done"); end
    checks++; if (rd_log.size() - rb != 15) begin errors++; $display("FAIL toggle_reads got %0d want 15", rd_log.size() - rb); end
    for (int i = 0; i < 15 && rb + i < rd_log.size(); i++) begin
      int lane = int'(exp_q[i][2*SIZE_W-1:SIZE_W]) % 4;
      checks++;
      if (rdy_arr[rd_log[rb+i].c % DEPTH] !== 1'b1 || rd_log[rb+i].v !== 4'(1 << lane)) begin
        errors++; $display("FAIL toggle_read%0d got %b ready %b want %b ready 1", i, rd_log[rb+i].v, rdy_arr[rd_log[rb+i].c % DEPTH], 4'(1 << lane));
      end
    end
    for (int i = 0; i < 15 && pb + i < pe_log.size(); i++) begin
      pe_t p = pe_log[pb+i];
      checks++;
      if ({p.r, p.k} !== exp_q[i] || p.l !== (i == 14)) begin
        errors++; $display("FAIL toggle_pe%0d got (%0d,%0d) last %b want (%0d,%0d) last %b", i, p.r, p.k, p.l,
                           exp_q[i][2*SIZE_W-1:SIZE_W], exp_q[i][SIZE_W-1:0], (i == 14));
      end
    end
  endtask

  task automatic test_start_ignored();
    int s, rb, pb, db;
    bit ok;
    set_stim(cyc + 1, 60, 0);
    rb = rd_log.size(); pb = pe_log.size(); db = done_log.size();
    launch(4, s);
    tick(); tick();
    bus.start = 1'b1; bus.matrix_size = SIZE_W'(3);
    tick();
    bus.start = 1'b0;
    wait_done(40, ok);
    repeat (5) tick();
    checks++; if (!ok) begin errors++; $display("FAIL ignore_timeout got no done want done"); end
    checks++; if (rd_log.size() - rb != 6) begin errors++; $display("FAIL ignore_reads got %0d want 6", rd_log.size() - rb); end
    checks++; if (done_log.size() - db != 1 || (ok && done_log[db] != s + 8)) begin errors++; $display("FAIL ignore_done got %0d pulses want 1 at 8", done_log.size() - db); end
    checks++;
    if (pe_log.size() - pb != 6 || pe_log[pe_log.size()-1].r != 3 || pe_log[pe_log.size()-1].k != 2 || pe_log[pe_log.size()-1].l !== 1'b1) begin
      errors++; $display("FAIL ignore_last got %0d elems last (%0d,%0d) want 6 elems last (3,2)",
                         pe_log.size() - pb, pe_log[pe_log.size()-1].r, pe_log[pe_log.size()-1].k);
    end
  endtask

  task automatic test_reset_midwalk();
    int s, rb, pb, db, lastc;
    bit ok;
    set_stim(cyc + 1, 80, 0);
    rb = rd_log.size(); pb = pe_log.size(); db = done_log.size();
    launch(5, s);
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge slow_clock);
    checks++; if (bus.busy !== 1'b0 || bus.pe_valid !== 1'b0) begin errors++; $display("FAIL midreset_idle got busy %b pe_valid %b want 0 0", bus.busy, bus.pe_valid); end
    repeat (10) tick();
    lastc = (rd_log.size() > rb) ? rd_log[rd_log.size()-1].c - s : -1;
    checks++; if (rd_log.size() - rb != 3 || lastc != 3) begin errors++; $display("FAIL midreset_reads got %0d last at %0d want 3 last at 3", rd_log.size() - rb, lastc); end
    checks++; if (pe_log.size() - pb != 2) begin errors++; $display("FAIL midreset_pe got %0d want 2", pe_log.size() - pb); end
    checks++; if (done_log.size() != db) begin errors++; $display("FAIL midreset_done got %0d pulses want 0", done_log.size() - db); end
    rb = rd_log.size(); pb = pe_log.size();
    launch(5, s);
    wait_done(40, ok);
    checks++; if (!ok || rd_log.size() - rb != 10) begin errors++; $display("FAIL midreset_rerun got %0d reads want 10", rd_log.size() - rb); end
    checks++;
    if (pe_log.size() - pb != 10 || pe_log[pe_log.size()-1].l !== 1'b1 || pe_log[pe_log.size()-1].r != 4 || pe_log[pe_log.size()-1].k != 3) begin
      errors++; $display("FAIL midreset_rerun_last got %0d elems last (%0d,%0d) want 10 elems last (4,3)",
                         pe_log.size() - pb, pe_log[pe_log.size()-1].r, pe_log[pe_log.size()-1].k);
    end
  endtask

  task automatic test_random();
    for (int w = 0; w < 7; w++) begin
      int n    = (w == 0) ? 63 : $urandom_range(2, 12);
      int mode = (w == 0) ? 0 : $urandom_range(0, 2);
      int win  = (w == 0) ? 2100 : 600;
      int s, rb, pb, sb, t, last_rd, cnt;
      int exp_c[$];
      bit ok;
      set_stim(cyc + 1, win, mode);
      set_stim(cyc + 1 + win, 100, 0);
      rb = rd_log.size(); pb = pe_log.size(); sb = stall_log.size();
      launch(n, s);
      wait_done(win + 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout n %0d got no done want done", w, n); end
      // Each element reads at the first cycle from the previous read on where its lane is full and the PE ready.
      build_order(n);
      cnt = exp_q.size();
      t = s + 1;
      foreach (exp_q[i]) begin
        int lane = int'(exp_q[i][2*SIZE_W-1:SIZE_W]) % 4;
        while (!(rdy_arr[t % DEPTH] && !emp_arr[t % DEPTH][lane]) && t < s + DEPTH - 200) t++;
        exp_c.push_back(t);
        t++;
      end
      last_rd = exp_c[cnt-1];
      checks++; if (rd_log.size() - rb != cnt) begin errors++; $display("FAIL rand%0d_reads n %0d got %0d want %0d", w, n, rd_log.size() - rb, cnt); end
      checks++; if (pe_log.size() - pb != cnt) begin errors++; $display("FAIL rand%0d_pes n %0d got %0d want %0d", w, n, pe_log.size() - pb, cnt); end
      for (int i = 0; i < cnt && rb + i < rd_log.size(); i++) begin
        int lane = int'(exp_q[i][2*SIZE_W-1:SIZE_W]) % 4;
        checks++;
        if (rd_log[rb+i].c != exp_c[i] || rd_log[rb+i].v !== 4'(1 << lane)) begin
          errors++; $display("FAIL rand%0d_read%0d got cyc %0d %b want cyc %0d %b", w, i, rd_log[rb+i].c - s, rd_log[rb+i].v, exp_c[i] - s, 4'(1 << lane));
        end
      end
      for (int i = 0; i < cnt && pb + i < pe_log.size(); i++) begin
        pe_t p = pe_log[pb+i];
        checks++;
        if (p.c != exp_c[i] + 1 || {p.r, p.k} !== exp_q[i] || p.l !== (i == cnt - 1)) begin
          errors++; $display("FAIL rand%0d_pe%0d got cyc %0d (%0d,%0d) last %b want cyc %0d (%0d,%0d) last %b", w, i, p.c - s, p.r, p.k, p.l,
                             exp_c[i] + 1 - s, exp_q[i][2*SIZE_W-1:SIZE_W], exp_q[i][SIZE_W-1:0], (i == cnt - 1));
        end
      end
      checks++; if (ok && done_log[done_log.size()-1] != last_rd + 2) begin errors++; $display("FAIL rand%0d_done got %0d want %0d", w, done_log[done_log.size()-1] - s, last_rd + 2 - s); end
      checks++; if (stall_log.size() - sb != (last_rd - s) - cnt) begin errors++; $display("FAIL rand%0d_stalls got %0d want %0d", w, stall_log.size() - sb, (last_rd - s) - cnt); end
`ifdef UKF_SCHED_STALL_CNT_EN
      checks++; if (bus.stall_cycles !== STALL_W'((last_rd - s) - cnt)) begin errors++; $display("FAIL rand%0d_stall_cycles got %0d want %0d", w, bus.stall_cycles, (last_rd - s) - cnt); end
`else
      checks++; if (bus.stall_cycles !== '0) begin errors++; $display("FAIL rand%0d_stall_cycles got %0d want 0", w, bus.stall_cycles); end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin emp_arr[i] = 4'b0000; rdy_arr[i] = 1'b1; end
    bus.start = 1'b0;
    bus.matrix_size = '0;
    bus.empty_l = 4'b0000;
    bus.pe_ready = 1'b1;
    test_reset();
    test_basic_n4();
    test_n1();
    test_lane_stall();
    test_ready_toggle();
    test_start_ignored();
    test_reset_midwalk();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ukf_lower_read_scheduler.md
Name: ukf_lower_read_scheduler

Overview:
- Sequences reads of the strictly-lower-triangle elements of an N x N matrix from the four lower-lane FIFOs (l1..l4) into the shared lower-triangle processing element (PE).
- Walks the triangle in column-major order. Row r is always sourced from lane r mod 4.
- Issues one FIFO read per element, only when the owning lane holds data and the PE can accept. Signals completion when the walk is done.
- Sits between the FIFO write controller (which fills the lanes) and the PE.

Parameters:
- SIZE_W, 6, width of matrix size and row/column indices.
- STALL_W, 16, width of the optional stall counter.

Ports:
- slow_clock  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request to begin a walk; sampled only in IDLE.
- matrix_size  in  SIZE_W  N; latched when start is accepted.
- empty_l  in  4  FIFO empty flags; bit k = lane k (bit0 = l1).
- pe_ready  in  1  PE can accept an element this cycle.
- fifo_rde_l  out  4  one-hot FIFO read enables (combinational).
- pe_valid  out  1  FIFO data for the element read last cycle is on the bus.
- pe_row  out  SIZE_W  row index of the pe_valid element.
- pe_col  out  SIZE_W  column index of the pe_valid element.
- pe_last  out  1  pe_valid element is the final one of the walk.
- busy  out  1  high in every state except IDLE.
- stall  out  1  in ISSUE, owning lane empty or pe_ready low.
- done  out  1  one-cycle completion pulse.
- stall_cycles  out  STALL_W  stall count (optional feature).

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; size, row and column registers clear to 0.
  - pe_valid, pe_last, done, pe_row, pe_col are 0 after the edge.
  - fifo_rde_l, stall and busy read 0 while in IDLE.
  - Reset mid-walk aborts immediately. No further reads are issued; FIFO contents are untouched.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On start=1, latch N = matrix_size, set col=0, row=1.
  - If N >= 2, go to ISSUE. If N < 2 (no lower elements), go straight to DONE; no reads occur.
- ISSUE:
  - Owning lane k = row[1:0]. An issue happens when empty_l[k]=0 and pe_ready=1.
  - On issue: fifo_rde_l = 1 << k in the same cycle, combinationally. All other bits are 0.
  - Otherwise fifo_rde_l = 0 and stall = 1.
  - Counter advance on issue:
    - If row == N-1 and col == N-2, this is the last element: go to DRAIN.
    - Else if row == N-1: col <= col+1, row <= col+2.
    - Else: row <= row+1.
- Read-to-PE timing (FIFO read latency is 1 cycle):
  - pe_valid is registered high in the cycle after each issue.
  - pe_row/pe_col carry the indices of that issue.
  - pe_last is set only for the final element.
  - pe_row/pe_col hold their value when pe_valid = 0.
- DRAIN: one cycle, in which the last pe_valid is presented; then go to DONE.
- DONE: done = 1 for exactly one cycle; then go to IDLE.
- start while busy is ignored; matrix_size changes during a walk are ignored.
- Element count is N(N-1)/2.
  - The max N representable in SIZE_W bits is valid.
  - Index arithmetic is SIZE_W bits wide; no wrap can occur because row <= N-1.
- pe_ready low during an issue cycle blocks that issue. No element is ever dropped or duplicated.
- Issue throughput is at most 1 element per cycle.

Optional Feature:
- Macro: UKF_SCHED_STALL_CNT_EN.
- With the macro:
  - stall_cycles counts cycles with stall = 1 and saturates at all-ones.
  - It clears to 0 on reset and when start is accepted.
  - It holds its value after done until the next start.
- Without the macro: stall_cycles is constant 0 and no counter register exists.

Test Plan:
- N=4, all lanes non-empty, pe_ready=1, start at cycle 0 ->
  - Reads in cycles 1-6 on lanes 1,2,3,2,3,3 (fifo_rde_l = 0010, 0100, 1000, 0100, 1000, 1000).
  - pe (row,col) = (1,0),(2,0),(3,0),(2,1),(3,1),(3,2) in cycles 2-7; pe_last in cycle 7.
  - done in cycle 8; busy = 0 in cycle 9.
- N=1, start -> no fifo_rde_l ever; done one cycle after start; busy high for exactly that cycle.
- N=4, empty_l[2]=1 held for 3 cycles when row 2 is due ->
  - stall = 1 for 3 cycles, fifo_rde_l = 0 during them.
  - Read of lane 2 occurs the cycle empty_l[2] falls; sequence otherwise unchanged.
  - With UKF_SCHED_STALL_CNT_EN, stall_cycles = 3 at done.
- N=6, pe_ready toggled every cycle ->
  - Exactly 15 reads, only in cycles with pe_ready = 1.
  - Indices follow column-major order; pe_last on the 15th.
- Reset asserted during the third read of an N=5 walk ->
  - From the next cycle: state IDLE, no further fifo_rde_l, pe_valid = 0, done never pulses.
  - A new start afterwards runs a full 10-element walk.
- start pulsed with N=3 while a walk is busy -> ignored; the original walk completes with its latched N.
